// File: rtl/matrix_mult_seq_pkg.sv
// matrix_pkg: shared types and helpers for the matrix-compute blocks.
//   state_t   - sequencer states (IDLE, MAC, DONE)
//   IDX_W     - index counter width, sized for the largest legal N
//   CVT_W     - container width used by the shared conversion function
//   elem_off  - bit offset of element (r,c) in a row-major packed matrix
//   cvt       - accumulator to element conversion (truncate / saturate)
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_MAX = 8;
  localparam int IDX_W = $clog2(N_MAX);
  // Wide enough for any accumulator with DW up to 30 and N up to 8.
  localparam int CVT_W = 64;

  // Element (0,0) sits in the MSBs.
  function automatic int elem_off(input int r, input int c, input int n, input int dw);
    return (n*n - 1 - (r*n + c)) * dw;
  endfunction

  // Result is in the low dw bits.
  function automatic logic [CVT_W-1:0] cvt(input logic [CVT_W-1:0] acc, input int dw,
                                          input logic sat);
    logic [CVT_W-1:0] mask;
    mask = (CVT_W'(1) << dw) - CVT_W'(1);
    if (sat && ((acc >> dw) != '0)) return mask;
    return acc & mask;
  endfunction

endpackage

// File: rtl/matrix_mult_seq_if.sv
// Operand / result bundle for matrix_mult_seq.
//   start, sat, a, b : request side (driven by master)
//   res, busy, done  : response side (driven by slave)
interface matrix_mult_seq_if #(
  parameter int N  = 2,
  parameter int DW = 8
);
  logic              start;
  logic              sat;
  logic [N*N*DW-1:0] a;
  logic [N*N*DW-1:0] b;
  logic [N*N*DW-1:0] res;
  logic              busy;
  logic              done;

  modport master (output start, sat, a, b, input res, busy, done);
  modport slave  (input start, sat, a, b, output res, busy, done);
endinterface

// File: rtl/matrix_mult_seq_mac_unit.sv
// mac_unit: single shared multiply-accumulate for the matrix multiplier.
//   clk, rst  : clock, synchronous active-low reset
//   i_clr     : zero the accumulator (takes priority over i_acc)
//   i_acc     : load acc + i_a*i_b
//   i_sat     : conversion mode for o_y
//   i_a, i_b  : DW-bit unsigned operands
//   o_y       : converted value of acc + i_a*i_b (the sum about to be stored)
module mac_unit
  import matrix_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_acc,
  input  logic          i_sat,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_y
);

  logic [AW-1:0] r_acc;
  logic [AW-1:0] w_acc_next;

  // Full-width product and sum: AW has room for N products of DW x DW.
  assign w_acc_next = r_acc + (AW'(i_a) * AW'(i_b));
  assign o_y        = DW'(cvt(CVT_W'(w_acc_next), DW, i_sat));

  always_ff @(posedge clk) begin
    if (!rst)       r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_acc) r_acc <= w_acc_next;
  end

endmodule

// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: sequential N x N unsigned matrix multiplier, C = A*B.
// One MAC per cycle, N^3 cycles from accept to done.
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : slave side of matrix_mult_seq_if (start/sat/a/b in, res/busy/done out)
module matrix_mult_seq
  import matrix_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int AW = 2*DW + $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  matrix_mult_seq_if.slave bus
);

  localparam int EW = N*N*DW;

  state_t           r_state;
  logic [IDX_W-1:0] r_i, r_j, r_k;
  logic [EW-1:0]    r_a, r_b, r_wbuf, r_res;
  logic             r_sat, r_done;

  logic             w_accept, w_mac, w_klast, w_jlast, w_ilast;
  logic [DW-1:0]    w_ea, w_eb, w_y;
  logic [EW-1:0]    w_wbuf_next;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_mac    = (r_state == MAC);
  assign w_klast  = (r_k == IDX_W'(N-1));
  assign w_jlast  = (r_j == IDX_W'(N-1));
  assign w_ilast  = (r_i == IDX_W'(N-1));

  assign w_ea = r_a[elem_off(int'(r_i), int'(r_k), N, DW) +: DW];
  assign w_eb = r_b[elem_off(int'(r_k), int'(r_j), N, DW) +: DW];

  // Accumulator restarts on accept and after each finished dot product.
  mac_unit #(.DW(DW), .AW(AW)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_accept || (w_mac && w_klast)),
    .i_acc (w_mac),
    .i_sat (r_sat),
    .i_a   (w_ea),
    .i_b   (w_eb),
    .o_y   (w_y)
  );

  // Working buffer with the current element merged in; used both for the
  // per-element write and for the final copy into res.
  always_comb begin
    w_wbuf_next = r_wbuf;
    w_wbuf_next[elem_off(int'(r_i), int'(r_j), N, DW) +: DW] = w_y;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sat   <= 1'b0;
      r_wbuf  <= '0;
      r_res   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_a     <= bus.a;
          r_b     <= bus.b;
          r_sat   <= bus.sat;
          r_i     <= '0;
          r_j     <= '0;
          r_k     <= '0;
          r_state <= MAC;
        end
        MAC: begin
          if (!w_klast) begin
            r_k <= r_k + IDX_W'(1);
          end else begin
            r_k    <= '0;
            r_wbuf <= w_wbuf_next;
            if (!w_jlast) begin
              r_j <= r_j + IDX_W'(1);
            end else begin
              r_j <= '0;
              if (!w_ilast) begin
                r_i <= r_i + IDX_W'(1);
              end else begin
                r_i     <= '0;
                r_res   <= w_wbuf_next;
                r_done  <= 1'b1;
                r_state <= DONE;
              end
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.res  = r_res;
  assign bus.busy = (r_state != IDLE);
  assign bus.done = r_done;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Self-checking bench for matrix_mult_seq: one N=2 and one N=3 instance,
// directed vectors plus random operands against a plain-arithmetic model.
module tb_matrix_mult_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_mult_seq_if #(.N(2), .DW(8)) bus2 ();
  matrix_mult_seq_if #(.N(3), .DW(8)) bus3 ();

  matrix_mult_seq #(.N(2), .DW(8)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  matrix_mult_seq #(.N(3), .DW(8)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- reference model ----
  function automatic logic [7:0] el(input logic [71:0] x, input int n, input int r, input int c);
    return x[((n*n - 1 - (r*n + c)) * 8) +: 8];
  endfunction

  function automatic logic [71:0] model(input int n, input logic [71:0] a, input logic [71:0] b,
                                        input bit sat);
    logic [71:0] m;
    longint      s;
    m = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += longint'(el(a, n, r, k)) * longint'(el(b, n, k, c));
        if (sat && s > 255) s = 255;
        m[((n*n - 1 - (r*n + c)) * 8) +: 8] = 8'(s);
      end
    return m;
  endfunction

  // ---- bus access by dimension ----
  task automatic drive(input int n, input bit st, input logic [71:0] a, input logic [71:0] b,
                       input bit sat);
    if (n == 2) begin
      bus2.start = st; bus2.a = a[31:0]; bus2.b = b[31:0]; bus2.sat = sat;
    end else begin
      bus3.start = st; bus3.a = a; bus3.b = b; bus3.sat = sat;
    end
  endtask

  task automatic set_start(input int n, input bit st);
    if (n == 2) bus2.start = st; else bus3.start = st;
  endtask

  function automatic logic [71:0] get_res(input int n);
    return (n == 2) ? {40'b0, bus2.res} : bus3.res;
  endfunction
  function automatic logic get_done(input int n);
    return (n == 2) ? bus2.done : bus3.done;
  endfunction
  function automatic logic get_busy(input int n);
    return (n == 2) ? bus2.busy : bus3.busy;
  endfunction

  // One full operation; poke re-pulses start mid-MAC with other operands.
  task automatic run_op(input int n, input logic [71:0] a, input logic [71:0] b, input bit sat,
                        input bit poke, input string tag);
    logic [71:0] exp, prev;
    int          cyc, extra;
    bit          seen, partial;
    exp  = model(n, a, b, sat);
    prev = get_res(n);
    @(negedge clk); drive(n, 1'b1, a, b, sat);
    @(negedge clk); set_start(n, 1'b0);
    chk({tag, " busy"}, 72'(get_busy(n)), 72'd1);
    cyc = 0; seen = 0; partial = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk); cyc++;
      if (poke && cyc == 3) drive(n, 1'b1, ~a, b ^ 72'h5a5a5a5a5a5a5a5a5a, ~sat);
      if (poke && cyc == 4) set_start(n, 1'b0);
      if (get_done(n)) seen = 1;
      else if (get_res(n) !== prev) partial = 1;
    end
    chk({tag, " done_seen"}, 72'(seen), 72'd1);
    chk({tag, " latency"}, 72'(cyc), 72'(n*n*n));
    chk({tag, " no_partial"}, 72'(partial), 72'd0);
    chk({tag, " res"}, get_res(n), exp);
    @(negedge clk);
    chk({tag, " done_clr"}, 72'(get_done(n)), 72'd0);
    chk({tag, " busy_clr"}, 72'(get_busy(n)), 72'd0);
    if (poke) begin
      extra = 0;
      for (int i = 0; i < n*n*n + 4; i++) begin
        @(negedge clk);
        if (get_done(n)) extra++;
      end
      chk({tag, " no_requeue"}, 72'(extra), 72'd0);
    end
  endtask

  logic [71:0] ra, rb, a1, b1, a2, b2, m1, m2, prev, expres;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive(2, 1'b0, '0, '0, 1'b0);
    drive(3, 1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst res2", get_res(2), '0);
    chk("rst busy2", 72'(bus2.busy), 72'd0);
    chk("rst done2", 72'(bus2.done), 72'd0);
    chk("rst res3", get_res(3), '0);
    chk("rst busy3", 72'(bus3.busy), 72'd0);
    chk("rst done3", 72'(bus3.done), 72'd0);

    // Directed vectors
    run_op(2, 72'h01020304, 72'h05060708, 1'b0, 1'b0, "vec1");
    chk("vec1 const", get_res(2), 72'h13162B32);
    run_op(2, 72'hFFFFFFFF, 72'hFFFFFFFF, 1'b0, 1'b0, "ff_trunc");
    chk("ff_trunc const", get_res(2), 72'h02020202);
    run_op(2, 72'hFFFFFFFF, 72'hFFFFFFFF, 1'b1, 1'b0, "ff_sat");
    chk("ff_sat const", get_res(2), 72'hFFFFFFFF);
    run_op(3, 72'h010000000100000001, 72'h010203040506070809, 1'b0, 1'b0, "ident_l");
    chk("ident_l const", get_res(3), 72'h010203040506070809);
    run_op(3, 72'h010203040506070809, 72'h010000000100000001, 1'b1, 1'b0, "ident_r");
    chk("ident_r const", get_res(3), 72'h010203040506070809);

    // start re-pulsed mid-MAC must be ignored
    run_op(2, 72'h0a0b0c0d, 72'h11223344, 1'b0, 1'b1, "poke2");
    run_op(3, 72'h090807060504030201, 72'h0f0e0d0c0b0a090807, 1'b1, 1'b1, "poke3");

    // Reset at MAC cycle 4
    @(negedge clk); drive(2, 1'b1, 72'h10203040, 72'h50607080, 1'b0);
    @(negedge clk); set_start(2, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst res", get_res(2), '0);
    chk("midrst busy", 72'(bus2.busy), 72'd0);
    chk("midrst done", 72'(bus2.done), 72'd0);
    rst = 1'b1;
    run_op(2, 72'h10203040, 72'h50607080, 1'b0, 1'b0, "after_rst");

    // start held high: accepts at E0 and E10, done after E8 and E18
    a1 = {40'b0, $urandom}; b1 = {40'b0, $urandom};
    a2 = {40'b0, $urandom}; b2 = {40'b0, $urandom};
    m1 = model(2, a1, b1, 1'b0);
    m2 = model(2, a2, b2, 1'b1);
    prev = get_res(2);
    @(negedge clk); drive(2, 1'b1, a1, b1, 1'b0);
    @(negedge clk); drive(2, 1'b1, a2, b2, 1'b1);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      expres = (cyc < 8) ? prev : (cyc < 18) ? m1 : m2;
      chk($sformatf("hold done c%0d", cyc), 72'(bus2.done), 72'((cyc == 8) || (cyc == 18)));
      chk($sformatf("hold busy c%0d", cyc), 72'(bus2.busy), 72'(!((cyc == 9) || (cyc >= 19))));
      chk($sformatf("hold res c%0d", cyc), get_res(2), expres);
      if (cyc == 18) set_start(2, 1'b0);
    end

    // Random operands
    for (int t = 0; t < 6; t++) begin
      ra = {$urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom};
      run_op(2, {40'b0, ra[31:0]}, {40'b0, rb[31:0]}, 1'($urandom_range(0, 1)), 1'b0,
             $sformatf("rnd2_%0d", t));
      run_op(3, ra, rb, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd3_%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
